// File: rtl/func_test_pkg.sv
// Shared encodings for the functional-test sequencer: FSM state codes and
// control-byte command values.
package func_test_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StPlay  = 2'd2,
        StDrain = 2'd3
    } state_e;

    localparam logic [7:0] CmdLoad  = 8'hAA;
    localparam logic [7:0] CmdPlay  = 8'hBB;
    localparam logic [7:0] CmdAbort = 8'hCC;
    localparam logic [3:0] CmdRptHi = 4'hD;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered (non-show-ahead) read data, occupancy
// count and synchronous clear. Read data is held until the next pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     sys_clk,
    input  logic                     n_rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr_en && !full && !clr;
    assign do_rd = rd_en && !empty && !clr;

    always_ff @(posedge sys_clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

endmodule

// File: rtl/func_test_seq.sv
// Functional-test sequencer: loads DAC samples from byte stream, replays them
// with BOS pixel timing, captures ADC words and drains them as bytes to the PC.
module func_test_seq
    import func_test_pkg::*;
#(
    parameter int unsigned DAC_W  = 14,
    parameter int unsigned ADC_W  = 12,
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned DIV    = 8,
    parameter int unsigned SHP_PH = 1,
    parameter int unsigned SHD_PH = 5
) (
    input  logic             sys_clk,
    input  logic             n_rst,
    input  logic             cmd_valid,
    input  logic [7:0]       cmd_data,
    input  logic             smp_valid,
    input  logic [7:0]       smp_data,
    input  logic             rd_req,
    output logic             have_msg,
    output logic [7:0]       out_data,
    output logic [DAC_W-1:0] dac_d,
    input  logic [ADC_W-1:0] adc_q,
    input  logic             adc_valid,
    output logic             clk_fpga,
    output logic             shp_fpga,
    output logic             shd_fpga,
    output logic             busy,
    output logic             ovf,
    output logic [1:0]       state_dbg
);

    localparam int unsigned CW = $clog2(DEPTH);
    localparam int unsigned PW = $clog2(DIV);

    state_e           state_q, state_d;
    logic [3:0]       rpt_q, rpt_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [3:0]       pass_q, pass_d;
    logic [CW:0]      n_q, n_d;
    logic [7:0]       lo_q;
    logic             lo_vld_q, lo_vld_d;
    logic             ovf_q;
    logic [DAC_W-1:0] dac_q, dac_nxt;
    logic             clk_q, shp_q, shd_q;
    logic             hi_pend_q, out_sel_q;

    logic             is_abort, is_start, is_rpt, is_play;
    logic             ph_end, idx_last, last_pix;
    logic             load_wr, play_wr, smp_wr, smp_rd, smp_full;
    logic [15:0]      pair16;
    logic [DAC_W-1:0] smp_wdata, smp_rd_data;
    logic [CW:0]      smp_count;
    logic             cap_clr, cap_wr, cap_rd, cap_full, cap_empty;
    logic [15:0]      cap_rd_data;
    logic [CW:0]      cap_count;
    logic             rd_go;

    assign is_abort = cmd_valid && (cmd_data == CmdAbort);
    assign is_start = cmd_valid && (cmd_data == CmdLoad) && (state_q == StIdle);
    assign is_rpt   = cmd_valid && (cmd_data[7:4] == CmdRptHi) && (state_q == StIdle);
    assign is_play  = cmd_valid && (cmd_data == CmdPlay) && (state_q == StLoad) &&
                      (smp_count != '0);

    assign ph_end   = (phase_q == PW'(DIV - 1));
    assign idx_last = ({1'b0, idx_q} == n_q - (CW+1)'(1));
    assign last_pix = (state_q == StPlay) && ph_end && idx_last && (pass_q == rpt_q);

    // Playback recirculates: each sample is popped for its pixel and pushed
    // back during phase 0, so the buffer survives replay and abort.
    assign pair16    = {smp_data, lo_q};
    assign load_wr   = (state_q == StLoad) && smp_valid && lo_vld_q;
    assign play_wr   = (state_q == StPlay) && (phase_q == '0);
    assign smp_wr    = load_wr || play_wr;
    assign smp_wdata = play_wr ? smp_rd_data : pair16[DAC_W-1:0];
    assign smp_rd    = is_play || ((state_q == StPlay) && ph_end && !last_pix && !is_abort);

    assign cap_clr = is_start || is_abort;
    assign cap_wr  = (state_q == StPlay) && adc_valid;

    assign have_msg = (state_q == StDrain) && (!cap_empty || hi_pend_q);
    assign rd_go    = rd_req && have_msg;
    assign cap_rd   = rd_go && !hi_pend_q;

    sync_fifo #(
        .WIDTH (DAC_W),
        .DEPTH (DEPTH)
    ) u_smp_buf (
        .sys_clk (sys_clk),
        .n_rst   (n_rst),
        .clr     (is_start),
        .wr_en   (smp_wr),
        .wr_data (smp_wdata),
        .rd_en   (smp_rd),
        .rd_data (smp_rd_data),
        .count   (smp_count),
        .full    (smp_full),
        .empty   ()
    );

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) u_cap_fifo (
        .sys_clk (sys_clk),
        .n_rst   (n_rst),
        .clr     (cap_clr),
        .wr_en   (cap_wr),
        .wr_data (16'(adc_q)),
        .rd_en   (cap_rd),
        .rd_data (cap_rd_data),
        .count   (cap_count),
        .full    (cap_full),
        .empty   (cap_empty)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (is_start)  state_d = StLoad;
            StLoad:  if (is_play)   state_d = StPlay;
            StPlay:  if (last_pix)  state_d = StDrain;
            StDrain: if (!have_msg) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (is_abort) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        phase_d = '0;
        idx_d   = '0;
        pass_d  = '0;
        n_d     = is_play ? smp_count : n_q;
        if ((state_q == StPlay) && (state_d == StPlay)) begin
            phase_d = ph_end ? '0 : phase_q + PW'(1);
            idx_d   = idx_q;
            pass_d  = pass_q;
            if (ph_end) begin
                if (idx_last) begin
                    idx_d  = '0;
                    pass_d = pass_q + 4'd1;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
        end
    end

    always_comb begin
        rpt_d = rpt_q;
        if (is_rpt) begin
            rpt_d = cmd_data[3:0];
        end
        if ((state_q != StIdle) && (state_d == StIdle)) begin
            rpt_d = '0;
        end
        lo_vld_d = lo_vld_q;
        if (state_d != StLoad) begin
            lo_vld_d = 1'b0;
        end else if ((state_q == StLoad) && smp_valid) begin
            lo_vld_d = !lo_vld_q;
        end
        // Sample shown from the cycle after phase 0 until the next phase 0.
        dac_nxt = '0;
        if ((state_q == StPlay) && !is_abort) begin
            dac_nxt = (phase_q == '0) ? smp_rd_data : dac_q;
        end
    end

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= StIdle;
            rpt_q     <= '0;
            phase_q   <= '0;
            idx_q     <= '0;
            pass_q    <= '0;
            n_q       <= '0;
            lo_q      <= '0;
            lo_vld_q  <= 1'b0;
            ovf_q     <= 1'b0;
            dac_q     <= '0;
            clk_q     <= 1'b0;
            shp_q     <= 1'b1;
            shd_q     <= 1'b1;
            hi_pend_q <= 1'b0;
            out_sel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rpt_q    <= rpt_d;
            phase_q  <= phase_d;
            idx_q    <= idx_d;
            pass_q   <= pass_d;
            n_q      <= n_d;
            lo_vld_q <= lo_vld_d;
            dac_q    <= dac_nxt;
            if ((state_q == StLoad) && smp_valid && !lo_vld_q) begin
                lo_q <= smp_data;
            end
            if (is_start) begin
                ovf_q <= 1'b0;
            end else if ((load_wr && smp_full) || (cap_wr && cap_full && !cap_clr)) begin
                ovf_q <= 1'b1;
            end
            clk_q <= (state_d == StPlay) && (phase_d < PW'(DIV / 2));
            shp_q <= !((state_d == StPlay) && (phase_d == PW'(SHP_PH)));
            shd_q <= !((state_d == StPlay) && (phase_d == PW'(SHD_PH)));
            if (cap_clr) begin
                hi_pend_q <= 1'b0;
            end else if (rd_go) begin
                hi_pend_q <= !hi_pend_q;
            end
            if (rd_go) begin
                out_sel_q <= hi_pend_q;
            end
        end
    end

    assign out_data  = out_sel_q ? cap_rd_data[15:8] : cap_rd_data[7:0];
    assign dac_d     = dac_q;
    assign clk_fpga  = clk_q;
    assign shp_fpga  = shp_q;
    assign shd_fpga  = shd_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q == StPlay) || (state_q == StDrain);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_func_test_seq.sv
// Scoreboard bench for func_test_seq: random and directed load/play/drain runs
// checked against a queue-based model of samples, captures and pixel timing.
module tb_func_test_seq;

    localparam int DAC_W  = 14;
    localparam int ADC_W  = 12;
    localparam int DEPTH  = 16;
    localparam int DIV    = 8;
    localparam int SHP_PH = 1;
    localparam int SHD_PH = 5;

    logic             sys_clk;
    logic             n_rst;
    logic             cmd_valid;
    logic [7:0]       cmd_data;
    logic             smp_valid;
    logic [7:0]       smp_data;
    logic             rd_req;
    logic             have_msg;
    logic [7:0]       out_data;
    logic [DAC_W-1:0] dac_d;
    logic [ADC_W-1:0] adc_q;
    logic             adc_valid;
    logic             clk_fpga;
    logic             shp_fpga;
    logic             shd_fpga;
    logic             busy;
    logic             ovf;
    logic [1:0]       state_dbg;

    func_test_seq #(
        .DAC_W  (DAC_W),
        .ADC_W  (ADC_W),
        .DEPTH  (DEPTH),
        .DIV    (DIV),
        .SHP_PH (SHP_PH),
        .SHD_PH (SHD_PH)
    ) dut (
        .sys_clk   (sys_clk),
        .n_rst     (n_rst),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .smp_valid (smp_valid),
        .smp_data  (smp_data),
        .rd_req    (rd_req),
        .have_msg  (have_msg),
        .out_data  (out_data),
        .dac_d     (dac_d),
        .adc_q     (adc_q),
        .adc_valid (adc_valid),
        .clk_fpga  (clk_fpga),
        .shp_fpga  (shp_fpga),
        .shd_fpga  (shd_fpga),
        .busy      (busy),
        .ovf       (ovf),
        .state_dbg (state_dbg)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_dac[$];
    int exp_byte[$];
    int stim_vals[$];
    int stim_adc[$];
    int samples[$];
    int cap[$];
    bit ovf_exp;
    bit chk_en = 1'b1;
    bit rd_pend = 1'b0;
    bit prev_play = 1'b0;
    int play_cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic cmd(input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_data  = b;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic smp(input logic [7:0] b);
        smp_valid = 1'b1;
        smp_data  = b;
        tick();
        smp_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_state"}, int'(state_dbg), 0);
        chk({tag, "_dac"}, int'(dac_d), 0);
        chk({tag, "_clk"}, int'(clk_fpga), 0);
        chk({tag, "_shp"}, int'(shp_fpga), 1);
        chk({tag, "_shd"}, int'(shd_fpga), 1);
        chk({tag, "_have_msg"}, int'(have_msg), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    // Monitor: everything checked on the falling edge, away from DUT updates.
    always @(negedge sys_clk) begin
        if (!n_rst) begin
            rd_pend   = 1'b0;
            prev_play = 1'b0;
            play_cyc  = 0;
        end else begin
            if (rd_pend) begin
                if (exp_byte.size() == 0) chk("byte_extra", int'(out_data), -1);
                else chk("out_data", int'(out_data), exp_byte.pop_front());
            end
            rd_pend = rd_req && have_msg;
            if (chk_en && prev_play) begin
                if (exp_dac.size() == 0) chk("dac_extra", int'(dac_d), -1);
                else chk("dac_d", int'(dac_d), exp_dac.pop_front());
            end else if (state_dbg != 2'd2 && !prev_play) begin
                chk("dac_idle", int'(dac_d), 0);
            end
            if (state_dbg == 2'd2) begin
                chk("clk_fpga", int'(clk_fpga), int'((play_cyc % DIV) < DIV / 2));
                chk("shp_fpga", int'(shp_fpga), int'((play_cyc % DIV) != SHP_PH));
                chk("shd_fpga", int'(shd_fpga), int'((play_cyc % DIV) != SHD_PH));
                play_cyc++;
            end else begin
                play_cyc = 0;
                chk("clk_idle", int'(clk_fpga), 0);
                chk("shp_idle", int'(shp_fpga), 1);
                chk("shd_idle", int'(shd_fpga), 1);
            end
            prev_play = (state_dbg == 2'd2);
        end
    end

    // One full sequence from stim_vals/stim_adc; optional abort or reset.
    task automatic run(input int r, input bit tail, input bit rand_adc,
                       input int abort_at, input bit rst_drain);
        int  n;
        int  plays;
        int  ai;
        int  guard;
        bit  entered;
        samples.delete();
        cap.delete();
        ovf_exp = 1'b0;
        if (r > 1) cmd(8'(8'hD0 + r - 1));
        cmd(8'hAA);
        foreach (stim_vals[i]) begin
            smp(8'(stim_vals[i] & 8'hFF));
            smp_valid = 1'b1;
            smp_data  = 8'(stim_vals[i] >> 8);
            if ($urandom_range(0, 3) == 0) begin
                cmd_valid = 1'b1;
                cmd_data  = ($urandom_range(0, 1) == 0) ? 8'hAA : 8'h42;
            end
            tick();
            smp_valid = 1'b0;
            cmd_valid = 1'b0;
            if ($urandom_range(0, 2) == 0) tick();
            if (samples.size() < DEPTH) samples.push_back(stim_vals[i] & ((1 << DAC_W) - 1));
            else ovf_exp = 1'b1;
        end
        if (tail) smp(8'($urandom));
        n = samples.size();
        for (int p = 0; p < r; p++)
            for (int s = 0; s < n; s++)
                for (int d = 0; d < DIV; d++) exp_dac.push_back(samples[s]);
        plays   = 0;
        ai      = 0;
        entered = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = 8'hBB;
        for (guard = 0; guard < 20000; guard++) begin
            tick();
            cmd_valid = 1'b0;
            adc_valid = 1'b0;
            if (state_dbg == 2'd2) begin
                entered = 1'b1;
                plays++;
                if (abort_at >= 0 && plays == abort_at) begin
                    chk_en    = 1'b0;
                    cmd_valid = 1'b1;
                    cmd_data  = 8'hCC;
                    tick();
                    cmd_valid = 1'b0;
                    check_idle_outputs("abort");
                    exp_dac.delete();
                    tick();
                    chk_en = 1'b1;
                    return;
                end
                if (ai < stim_adc.size()) begin
                    adc_valid = 1'b1;
                    adc_q     = ADC_W'(stim_adc[ai]);
                    ai++;
                end else if (rand_adc && $urandom_range(0, 2) == 0) begin
                    adc_valid = 1'b1;
                    adc_q     = ADC_W'($urandom);
                end
                if (adc_valid) begin
                    if (cap.size() < DEPTH) cap.push_back(int'(adc_q));
                    else ovf_exp = 1'b1;
                end
            end else if (entered) begin
                adc_valid = ($urandom_range(0, 1) == 0);
                adc_q     = ADC_W'($urandom);
                break;
            end
        end
        chk("play_entry", int'(entered), 1);
        chk("play_len", plays, n * r * DIV);
        foreach (cap[i]) begin
            exp_byte.push_back(cap[i] & 8'hFF);
            exp_byte.push_back(cap[i] >> 8);
        end
        for (guard = 0; guard < 4000; guard++) begin
            tick();
            rd_req    = 1'b0;
            adc_valid = 1'b0;
            if (state_dbg == 2'd0) break;
            if (rst_drain && guard == 3) begin
                #2 n_rst = 1'b0;
                #1 check_idle_outputs("rst_drain");
                chk("rst_drain_out", int'(out_data), 0);
                chk("rst_drain_ovf", int'(ovf), 0);
                exp_byte.delete();
                exp_dac.delete();
                tick();
                tick();
                n_rst = 1'b1;
                tick();
                check_idle_outputs("after_rst");
                return;
            end
            rd_req = ($urandom_range(0, 3) != 0);
        end
        chk("drain_done", int'(guard < 4000), 1);
        rd_req = 1'b0;
        tick();
        tick();
        chk("bytes_left", exp_byte.size(), 0);
        chk("dac_left", exp_dac.size(), 0);
        chk("ovf", int'(ovf), int'(ovf_exp));
        chk("state_end", int'(state_dbg), 0);
        chk("have_msg_end", int'(have_msg), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        smp_valid = 1'b0;
        smp_data  = '0;
        rd_req    = 1'b0;
        adc_q     = '0;
        adc_valid = 1'b0;
        #12;
        check_idle_outputs("reset");
        chk("reset_out", int'(out_data), 0);
        chk("reset_ovf", int'(ovf), 0);
        #11 n_rst = 1'b1;
        tick();

        // Play with nothing loaded (or only a stray low byte) is ignored.
        cmd(8'hAA);
        cmd(8'hBB);
        chk("bb_empty", int'(state_dbg), 1);
        smp(8'h55);
        cmd(8'hBB);
        chk("bb_half", int'(state_dbg), 1);
        cmd(8'hCC);
        chk("abort_load", int'(state_dbg), 0);

        stim_vals = '{32'h1234, 32'hFFFF};
        stim_adc.delete();
        run(1, 1'b0, 1'b0, -1, 1'b0);

        stim_vals = '{int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535))};
        run(3, 1'b0, 1'b1, -1, 1'b0);

        stim_vals.delete();
        for (int i = 0; i < DEPTH + 1; i++) stim_vals.push_back(int'($urandom_range(0, 65535)));
        run(1, 1'b0, 1'b1, -1, 1'b0);

        stim_vals = '{32'h0123};
        stim_adc  = '{32'hABC, 32'h001, 32'hFFF};
        run(1, 1'b0, 1'b0, -1, 1'b0);

        stim_adc.delete();
        for (int k = 0; k < 6; k++) begin
            stim_vals.delete();
            for (int i = 0; i < int'($urandom_range(1, DEPTH + 2)); i++)
                stim_vals.push_back(int'($urandom_range(0, 65535)));
            run(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'b1, -1, 1'b0);
        end

        stim_vals = '{32'h1111, 32'h2222, 32'h3333};
        run(2, 1'b0, 1'b1, 10, 1'b0);

        stim_vals = '{32'h0456};
        stim_adc  = '{32'hABC, 32'h001, 32'hFFF};
        run(1, 1'b0, 1'b0, -1, 1'b1);

        stim_adc.delete();
        stim_vals = '{32'h2AAA, 32'h1555};
        run(2, 1'b1, 1'b1, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/func_test_seq.md
FUNC_TEST_SEQ -- requirements
Module: func_test_seq

Interface
REQ-001 Parameter DAC_W, default 14, DAC sample width.
REQ-002 Parameter ADC_W, default 12, captured sample width.
REQ-003 Parameter DEPTH, default 512, samples per buffer, power of two, >=8.
REQ-004 Parameter DIV, default 8, sys_clk cycles per pixel, even, >=4.
REQ-005 Parameters SHP_PH / SHD_PH, defaults 1 / 5, phases (0..DIV-1) at which shp_fpga / shd_fpga pulse low.
REQ-006 Port sys_clk  in  1  system clock; all logic on its rising edge.
REQ-007 Port n_rst  in  1  reset, asynchronous, active-low.
REQ-008 Port cmd_valid / cmd_data  in  1 / 8  control byte strobe and value.
REQ-009 Port smp_valid / smp_data  in  1 / 8  sample byte strobe and value.
REQ-010 Port rd_req  in  1  PC read request for one result byte.
REQ-011 Port have_msg  out  1  result bytes available.
REQ-012 Port out_data  out  8  result byte.
REQ-013 Port dac_d  out  DAC_W  DAC code.
REQ-014 Port adc_q / adc_valid  in  ADC_W / 1  BOS output word and strobe, already in sys_clk domain.
REQ-015 Ports clk_fpga, shp_fpga, shd_fpga  out  1 each  BOS timing.
REQ-016 Ports busy, ovf  out  1 each  sequence active; sticky overflow flag.
REQ-017 Port state_dbg  out  2  current state code.

Function
REQ-018 States IDLE=0, LOAD=1, PLAY=2, DRAIN=3.
REQ-019 Commands: 0xAA start load, 0xBB play, 0xCC abort, 0xD0-0xDF set repeat count R = low nibble + 1; all other codes ignored.
REQ-020 IDLE: 0xAA -> LOAD, clears sample buffer, capture FIFO and ovf; 0xDn accepted only in IDLE; R resets to 1.
REQ-021 LOAD: smp_valid bytes pair into samples, low byte first; sample = lower DAC_W bits of 16-bit value; written when high byte arrives.
REQ-022 LOAD: write when buffer holds DEPTH samples is dropped and ovf set.
REQ-023 LOAD: 0xBB with >=1 complete sample -> PLAY; with zero samples ignored; pending unpaired low byte discarded.
REQ-024 PLAY: phase counter 0..DIV-1 per pixel; sample index advances at phase DIV-1; dac_d updated at phase 0 (registered, 1 cycle after entry for sample 0).
REQ-025 PLAY: clk_fpga high for phases 0..DIV/2-1, low otherwise; shp_fpga low only at SHP_PH; shd_fpga low only at SHD_PH.
REQ-026 PLAY: buffer replayed R times; after phase DIV-1 of last sample of last pass -> DRAIN.
REQ-027 PLAY: each adc_valid stores adc_q zero-extended to 16 bits into capture FIFO (DEPTH words); when full, word dropped and ovf set.
REQ-028 Outside PLAY: dac_d=0, clk_fpga=0, shp_fpga=1, shd_fpga=1, adc_valid ignored.
REQ-029 have_msg = (state==DRAIN) and capture FIFO not empty (byte-level).
REQ-030 Read: rd_req while have_msg -> out_data valid next cycle, low byte then high byte per word; rd_req without have_msg ignored, out_data holds.
REQ-031 DRAIN: after last byte read and no read pending -> IDLE.
REQ-032 0xCC in any state -> IDLE next cycle, capture FIFO flushed, timing outputs to idle values; sample buffer retained.
REQ-033 busy = state is PLAY or DRAIN; state_dbg = state code.
REQ-034 Simultaneous cmd_valid and smp_valid in LOAD: command processed, sample byte still stored.

Reset
REQ-035 On n_rst low: state IDLE, R=1, all counters/pointers 0, dac_d=0, out_data=0, clk_fpga=0, shp_fpga=1, shd_fpga=1, ovf=0, have_msg=0, busy=0.
REQ-036 Reset mid-PLAY/DRAIN discards all buffered data; outputs reach reset values asynchronously.

Structure
REQ-037 Shared package func_test_pkg holds state encoding and command code constants.
REQ-038 Sample buffer and capture FIFO each instantiate sub-module sync_fifo (parametrised width/depth, single clock, count output, non-show-ahead).

Verification
REQ-039 Load 0x34,0x12,0xFF,0x3F; 0xBB -> dac_d shows 0x1234 for 8 cycles then 0x3FFF, then DRAIN.
REQ-040 DIV=8, one sample: clk_fpga high phases 0-3, shp_fpga low phase 1 only, shd_fpga low phase 5 only.
REQ-041 0xD2 then load 2 samples, play -> 3 passes, 6 pixel periods (48 cycles) busy in PLAY.
REQ-042 DEPTH+1 samples loaded -> ovf=1, playback length DEPTH.
REQ-043 3 adc_valid with adc_q 0xABC,0x001,0xFFF -> reads return 0xBC,0x0A,0x01,0x00,0xFF,0x0F, then IDLE.
REQ-044 0xCC mid-PLAY -> IDLE next cycle, shp/shd=1, have_msg=0; n_rst pulse mid-DRAIN -> all REQ-035 values.
